// File: rtl/serial_link_credit_return.sv
`default_nettype none
// ============================================================================
// Module   : serial_link_credit_return
// Purpose  : Receive-side credit accounting. Tracks how full the receive
//            buffer is, collects freed slots as credits for the peer, and
//            requests a credit-only flit on backlog or age-out.
// Revision : 1.0
// ============================================================================
module serial_link_credit_return #(
    parameter int NUM_CREDITS     = 8,
    parameter int FORCE_THRESH    = 4,
    parameter int MAX_IDLE_CYCLES = 64,
    parameter int CREDIT_WIDTH    = $clog2(NUM_CREDITS) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flit_rcvd_i,
    input  logic                    flit_consumed_i,
    output logic [CREDIT_WIDTH-1:0] credits_o,
    output logic                    credits_force_o,
    input  logic                    credits_taken_i,
    output logic [CREDIT_WIDTH-1:0] occupancy_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int TIMER_WIDTH = $clog2(MAX_IDLE_CYCLES + 1);

    localparam logic [CREDIT_WIDTH:0]     c_NUM_CREDITS = (CREDIT_WIDTH+1)'(NUM_CREDITS);
    localparam logic [CREDIT_WIDTH-1:0]   c_THRESH      = CREDIT_WIDTH'(FORCE_THRESH);
    localparam logic [TIMER_WIDTH-1:0]    c_TIMER_LAST  = TIMER_WIDTH'(MAX_IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [TIMER_WIDTH-1:0]  r_timer;
    logic [CREDIT_WIDTH-1:0] r_occ;
    logic [CREDIT_WIDTH-1:0] r_pend;
    logic                    r_force;
    logic                    r_ovf;
    logic                    r_unf;

    logic [CREDIT_WIDTH:0]   w_in_use;
    logic                    w_rcvd_ok;
    logic                    w_cons_ok;
    logic [CREDIT_WIDTH-1:0] w_pend_base;
    logic [CREDIT_WIDTH-1:0] w_pend_next;
    logic [CREDIT_WIDTH-1:0] w_occ_next;

    // Slots the peer believes are consumed: buffered flits plus credits not yet returned.
    assign w_in_use    = {1'b0, r_occ} + {1'b0, r_pend};
    assign w_rcvd_ok   = flit_rcvd_i && (w_in_use < c_NUM_CREDITS);
    assign w_cons_ok   = flit_consumed_i && (r_occ != '0);
    assign w_pend_base = credits_taken_i ? '0 : r_pend;
    assign w_pend_next = w_pend_base + CREDIT_WIDTH'(w_cons_ok);
    assign w_occ_next  = r_occ + CREDIT_WIDTH'(w_rcvd_ok) - CREDIT_WIDTH'(w_cons_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_occ   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_occ   <= w_occ_next;
            r_pend  <= w_pend_next;
            if (flit_rcvd_i && !w_rcvd_ok) begin
                r_ovf <= 1'b1;
            end
            if (flit_consumed_i && (r_occ == '0)) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Threshold and age checks look at the registered backlog, so the force
    // request trails the backlog reaching the threshold by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_force <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    r_force <= 1'b0;
                    if (w_pend_next != '0) begin
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (credits_taken_i) begin
                        r_timer <= '0;
                        r_force <= 1'b0;
                        r_state <= (w_pend_next != '0) ? ST_ACCUM : ST_IDLE;
                    end else if ((r_pend >= c_THRESH) || (r_timer == c_TIMER_LAST)) begin
                        r_timer <= '0;
                        r_force <= 1'b1;
                        r_state <= ST_FORCE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        r_force <= 1'b0;
                    end
                end
                ST_FORCE: begin
                    r_timer <= '0;
                    if (credits_taken_i) begin
                        r_force <= 1'b0;
                        r_state <= (w_pend_next != '0) ? ST_ACCUM : ST_IDLE;
                    end else begin
                        r_force <= 1'b1;
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_force <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign credits_o       = r_pend;
    assign credits_force_o = r_force;
    assign occupancy_o     = r_occ;
    assign overflow_o      = r_ovf;
    assign underflow_o     = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_serial_link_credit_return.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_link_credit_return
// Purpose  : Directed self-checking bench for serial_link_credit_return.
// Revision : 1.0
// ============================================================================
module tb_serial_link_credit_return;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          rcvd;
    logic          cons;
    logic          take;
    logic [CW-1:0] credits;
    logic          force_req;
    logic [CW-1:0] occ;
    logic          ovf;
    logic          unf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_link_credit_return #(
        .NUM_CREDITS    (8),
        .FORCE_THRESH   (4),
        .MAX_IDLE_CYCLES(64)
    ) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flit_rcvd_i    (rcvd),
        .flit_consumed_i(cons),
        .credits_o      (credits),
        .credits_force_o(force_req),
        .credits_taken_i(take),
        .occupancy_o    (occ),
        .overflow_o     (ovf),
        .underflow_o    (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rc, input logic cn, input logic tk);
        rcvd = rc;
        cons = cn;
        take = tk;
        @(posedge clk);
        #1;
        rcvd = 1'b0;
        cons = 1'b0;
        take = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        rcvd = 1'b0;
        cons = 1'b0;
        take = 1'b0;

        // Reset state, fill to capacity, then overflow
        do_reset();
        check_eq("rst_credits", int'(credits), 0);
        check_eq("rst_occ", int'(occ), 0);
        check_eq("rst_force", int'(force_req), 0);
        check_eq("rst_ovf", int'(ovf), 0);
        check_eq("rst_unf", int'(unf), 0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
        check_eq("fill_occ", int'(occ), 8);
        check_eq("fill_credits", int'(credits), 0);
        check_eq("fill_ovf", int'(ovf), 0);
        check_eq("fill_unf", int'(unf), 0);
        tick(1'b1, 1'b0, 1'b0);
        check_eq("ovf_flag", int'(ovf), 1);
        check_eq("ovf_occ", int'(occ), 8);

        // Threshold-driven force and take
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            check_eq($sformatf("thr_credits_%0d", i), int'(credits), i);
            check_eq($sformatf("thr_force_%0d", i), int'(force_req), 0);
        end
        tick(1'b0, 1'b0, 1'b0);
        check_eq("thr_force_on", int'(force_req), 1);
        check_eq("thr_credits_hold", int'(credits), 4);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("thr_take_credits", int'(credits), 0);
        check_eq("thr_take_force", int'(force_req), 0);
        check_eq("thr_take_occ", int'(occ), 4);

        // Aging: force exactly 64 cycles after entering Accum
        do_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check_eq("age_credits", int'(credits), 1);
        idle(63);
        check_eq("age_force_63", int'(force_req), 0);
        idle(1);
        check_eq("age_force_64", int'(force_req), 1);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("age_take_credits", int'(credits), 0);
        check_eq("age_take_force", int'(force_req), 0);
        idle(1);
        check_eq("age_idle_force", int'(force_req), 0);

        // Take with same-cycle consume keeps Accum and restarts the timer
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check_eq("tc_credits_pre", int'(credits), 2);
        tick(1'b0, 1'b1, 1'b1);
        check_eq("tc_credits", int'(credits), 1);
        check_eq("tc_occ", int'(occ), 0);
        idle(63);
        check_eq("tc_force_63", int'(force_req), 0);
        idle(1);
        check_eq("tc_force_64", int'(force_req), 1);

        // Underflow, then simultaneous receive and consume
        do_reset();
        tick(1'b0, 1'b1, 1'b0);
        check_eq("unf_flag", int'(unf), 1);
        check_eq("unf_occ", int'(occ), 0);
        check_eq("unf_credits", int'(credits), 0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check_eq("both_occ", int'(occ), 3);
        check_eq("both_credits", int'(credits), 1);
        check_eq("both_unf_sticky", int'(unf), 1);

        // Mid-run reset with force asserted
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        idle(63);
        check_eq("mid_force", int'(force_req), 1);
        check_eq("mid_occ", int'(occ), 5);
        check_eq("mid_credits", int'(credits), 2);
        do_reset();
        check_eq("mid_rst_force", int'(force_req), 0);
        check_eq("mid_rst_occ", int'(occ), 0);
        check_eq("mid_rst_credits", int'(credits), 0);
        check_eq("mid_rst_ovf", int'(ovf), 0);
        check_eq("mid_rst_unf", int'(unf), 0);
        idle(1);
        check_eq("mid_rst_idle_force", int'(force_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_link_credit_return.md
Name: serial_link_credit_return

Overview:
- Receive-side credit accounting for the serial link, the counterpart of the sender's credit counter (credit_t, NumCredits outstanding).
- Tracks receive-buffer occupancy and slots freed by the consumer.
- Accumulates freed slots as credits for the peer, offered for piggybacking on outgoing flits. Forces a credit-only flit when the backlog crosses a threshold or ages out.
- Sits between the receive FIFO and the link send path of the local serial_link instance.

Parameters:
- NumCredits, 8: receive buffer depth; equals the peer's initial credit count.
- ForceThresh, 4: pending-credit count at which a forced credit return is requested (1..NumCredits).
- MaxIdleCycles, 64: cycles a non-zero credit backlog may wait before a forced return.
- CreditWidth, $clog2(NumCredits)+1: width of credit and occupancy values (credit_t).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- flit_rcvd_i  in  1  non-idle flit (tag != TagIdle) pushed into the receive FIFO this cycle.
- flit_consumed_i  in  1  downstream popped one flit from the receive FIFO this cycle.
- credits_o  out  CreditWidth  credits pending return (freed, not yet sent).
- credits_force_o  out  1  request for the send path to emit a credit-only (TagIdle) flit.
- credits_taken_i  in  1  send path embedded credits_o in an outgoing flit this cycle (piggyback or forced).
- occupancy_o  out  CreditWidth  receive-buffer slots in use.
- overflow_o  out  1  sticky: flit received while the peer had no credit.
- underflow_o  out  1  sticky: consume signalled with empty buffer.

Behaviour:
- Reset (rst_i high at a clock edge):
  - credits_o = 0, occupancy_o = 0, credits_force_o = 0.
  - overflow_o = 0, underflow_o = 0, age timer = 0, FSM = Idle.
  - Reset mid-operation discards all counts. The peer is expected to be reset together with this block.
- Occupancy update, next = occ + rcvd_ok - cons_ok, where:
  - rcvd_ok = flit_rcvd_i and (occ + pending < NumCredits).
  - cons_ok = flit_consumed_i and occ > 0.
  - Simultaneous accepted rcvd and consume leaves occ unchanged.
- Overflow: flit_rcvd_i while occ + pending == NumCredits sets overflow_o. The flit is not counted.
- Underflow: flit_consumed_i while occ == 0 sets underflow_o. The consume is ignored.
- Pending update, next = (credits_taken_i ? 0 : pending) + cons_ok.
  - Credits freed in the same cycle as a take are kept for the next return.
  - credits_taken_i with pending == 0 is legal and changes nothing.
- Invariant: occ + pending <= NumCredits at all times; pending never wraps.
- credits_o is a register output: the value sampled by the send path is the value taken. Latency from consume to credits_o is 1 cycle.
- FSM, next state evaluated on the updated pending value:
  - Idle: pending == 0; credits_force_o = 0; timer held at 0.
  - Idle -> Accum when pending becomes > 0.
  - Accum: timer increments each cycle; credits_force_o = 0.
  - Accum -> Force when pending >= ForceThresh, or timer == MaxIdleCycles-1.
  - Accum -> Idle on credits_taken_i with no same-cycle consume; timer cleared.
  - Accum stays Accum on credits_taken_i with a same-cycle consume; timer cleared.
  - Force: credits_force_o = 1, held until credits_taken_i. The value may grow while waiting.
  - Force -> Idle on take when the next pending is 0; Force -> Accum on take when the next pending is > 0. Timer is cleared either way.
  - credits_force_o deasserts in the cycle after the take.
- Threshold check uses the registered pending value:
  - credits_force_o asserts 1 cycle after pending reaches ForceThresh.
  - Aging: credits_force_o asserts MaxIdleCycles cycles after entering Accum.
- occupancy_o and the sticky flags are registered. Flags clear only on reset.

Test Plan:
- Reset, then 8 flit_rcvd_i and no consumes -> occupancy_o = 8, credits_o = 0, no flags. Then 1 more rcvd -> overflow_o = 1, occupancy_o stays 8.
- 8 rcvd, then 4 consecutive consumes -> credits_o goes 1,2,3,4 on successive cycles; credits_force_o = 1 one cycle after credits_o = 4. credits_taken_i pulse -> credits_o = 0, credits_force_o = 0 next cycle, occupancy_o = 4.
- 1 rcvd + 1 consume, no take -> credits_o = 1; credits_force_o asserts exactly 64 cycles after entering Accum. Take -> returns to Idle.
- credits_o = 2, credits_taken_i and flit_consumed_i same cycle -> credits_o = 1 next cycle, FSM in Accum, timer restarted.
- Empty buffer, flit_consumed_i -> underflow_o = 1, occupancy_o = 0, credits_o = 0. Same-cycle rcvd + consume with occ = 3 -> occupancy_o = 3, credits_o + 1.
- Mid-run rst_i with occ = 5, pending = 2, force asserted -> all outputs 0 next cycle, FSM Idle.
